// File: rtl/adc_serial_rx.sv
`default_nettype none
// adc_serial_rx: periodic SPI-style ADC reader; frames cs_n/sclk and captures a 12-bit MSB-first word.
// Revision: 1.0
module adc_serial_rx #(
  parameter int CLK_DIV       = 4,
  parameter int LEAD_BITS     = 3,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        overrun
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int BIT_W = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LEAD_BITS + 11);

  typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic [1:0]         sync_q, sync_d;
  logic [11:0]        shift_q, shift_d;
  logic [11:0]        sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               tick;

  assign tick = (period_q == PER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sync_q    <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = tick ? '0 : period_q + 1'b1;
    div_d     = div_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    sync_d    = {sync_q[0], adc_miso};
    shift_d   = shift_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = FRAME;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end
      FRAME: begin
        overrun_d = tick;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Last clk of a high phase: capture; lead bits simply shift out the top.
          if (sclk_q) begin
            shift_d = {shift_q[10:0], sync_q[1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        overrun_d = tick;
        sample_d  = shift_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc_sclk     = sclk_q;
  assign adc_cs_n     = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
endmodule
`default_nettype wire

// File: doc/adc_serial_rx.md
ADC_SERIAL_RX -- requirements
Module: adc_serial_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (>=2).
REQ-002 SHALL have parameter LEAD_BITS, default 3, dummy SCLK periods before the first data bit (0..7).
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 200, clk cycles between conversion starts; SHALL be >= 2*CLK_DIV*(LEAD_BITS+12)+2*CLK_DIV.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  permits new conversions while high.
REQ-007 SHALL have port adc_miso  input  1  serial data from ADC, MSB first.
REQ-008 SHALL have port adc_sclk  output  1  ADC serial clock, idle low.
REQ-009 SHALL have port adc_cs_n  output  1  ADC chip select, active low.
REQ-010 SHALL have port sample  output  12  last completed conversion, unsigned, feeds the mean stage serial_in.
REQ-011 SHALL have port sample_valid  output  1  one-clk pulse when sample updates.
REQ-012 SHALL have port overrun  output  1  one-clk pulse when a period tick is dropped.

Function
REQ-013 SHALL run a free-running period counter 0..SAMPLE_PERIOD-1; tick = counter at SAMPLE_PERIOD-1.
REQ-014 SHALL implement states IDLE, FRAME, DONE.
REQ-015 IDLE: on tick with enable=1 SHALL enter FRAME and drive adc_cs_n low on the next clk; tick with enable=0 SHALL be ignored.
REQ-016 FRAME: adc_sclk SHALL toggle every CLK_DIV clks, starting low for CLK_DIV clks after cs_n falls, for exactly LEAD_BITS+12 full periods.
REQ-017 adc_miso SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be captured on the last clk of each SCLK-high phase.
REQ-018 Captures during the first LEAD_BITS SCLK periods SHALL be discarded; the next 12 SHALL shift into a 12-bit register MSB first.
REQ-019 After the final SCLK falling edge the FSM SHALL enter DONE; in DONE adc_cs_n SHALL go high, sample SHALL load the shift register and sample_valid SHALL pulse for exactly one clk, then return to IDLE.
REQ-020 Frame length SHALL be 2*CLK_DIV*(LEAD_BITS+12) clks from cs_n low to DONE (120 at defaults).
REQ-021 A tick occurring in FRAME or DONE SHALL not start a conversion and SHALL pulse overrun for one clk.
REQ-022 enable falling mid-frame SHALL NOT abort; the frame SHALL complete and deliver sample_valid.
REQ-023 sample SHALL hold its value between sample_valid pulses.
REQ-024 adc_sclk and adc_cs_n SHALL be driven directly from flops (glitch-free).

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, adc_cs_n=1, adc_sclk=0, sample=0, sample_valid=0, overrun=0, period counter=0, shift register and synchronizer=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no sample_valid; after release the first conversion SHALL start on the first tick with enable=1.

Verification
REQ-027 Defaults, enable=1, ADC model returns 0xA5C after 3 lead bits -> cs_n low 120 clks, 15 SCLK pulses, sample=0xA5C with one sample_valid pulse, repeating every 200 clks.
REQ-028 Model returns 0xFFF then 0x000 -> consecutive sample_valid pulses show 0xFFF then 0x000; no stale bits.
REQ-029 enable dropped 10 clks after cs_n falls -> frame completes, sample valid delivered, no further cs_n activity until enable=1 and next tick.
REQ-030 rst_n pulsed low at clk 60 of a frame -> cs_n=1, sclk=0, sample=0 same cycle asynchronously; no sample_valid for that frame.
REQ-031 SAMPLE_PERIOD forced to 100 with defaults (illegal, frame 120) -> overrun pulses on ticks inside frames, conversions start only from IDLE.
REQ-032 CLK_DIV=2, LEAD_BITS=0, value 0x001 -> SCLK half-period 2 clks, frame 48 clks, sample=0x001.
